// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit between the pipeline and a single-port word memory
// Sub-word stores are read-modify-write; loads are little-endian with optional sign extension.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH+1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_misaligned,
    output logic                  o_stall,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LD_WAIT, LD_DATA, RMW_WAIT, RMW_MERGE, ST_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              size_q;
    logic [1:0]              lane_q;
    logic                    uns_q;
    logic [15:0]             wdata_q;

    logic                    accept;
    logic                    misaligned;
    logic [4:0]              byte_sh;
    logic [4:0]              half_sh;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_ext;
    logic [DATA_WIDTH-1:0]   merged;

    logic                    valid_d;
    logic                    mis_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_d;

    assign o_ready = (state_q == IDLE);
    assign o_stall = (state_q != IDLE);
    assign accept  = i_req && (state_q == IDLE);

    assign misaligned = (i_size == 2'b11) ||
                        ((i_size == 2'b01) && i_addr[0]) ||
                        ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));

    assign byte_sh = {lane_q, 3'b000};
    assign half_sh = {lane_q[1], 4'b0000};
    assign ld_byte = i_mem_rdata[byte_sh +: 8];
    assign ld_half = i_mem_rdata[half_sh +: 16];

    always_comb begin
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        merged = i_mem_rdata;
        if (size_q == 2'b00) begin
            merged[byte_sh +: 8] = wdata_q[7:0];
        end else begin
            merged[half_sh +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_rdata      <= '0;
        end else begin
            state_q      <= state_d;
            o_valid      <= valid_d;
            o_misaligned <= mis_d;
            o_mem_we     <= we_d;
            o_mem_addr   <= addr_d;
            o_mem_wdata  <= wdata_d;
            o_rdata      <= rdata_d;
            if (accept) begin
                size_q  <= i_size;
                lane_q  <= i_addr[1:0];
                uns_q   <= i_unsigned;
                wdata_q <= i_wdata[15:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    if (!i_wr)                  state_d = LD_WAIT;
                    else if (i_size == 2'b10)   state_d = ST_WRITE;
                    else                        state_d = RMW_WAIT;
                end
            end
            LD_WAIT:   state_d = LD_DATA;
            LD_DATA:   state_d = IDLE;
            RMW_WAIT:  state_d = RMW_MERGE;
            RMW_MERGE: state_d = ST_WRITE;
            ST_WRITE:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; address and write data hold unless updated.
    always_comb begin
        valid_d = 1'b0;
        mis_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = o_mem_addr;
        wdata_d = o_mem_wdata;
        rdata_d = o_rdata;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = i_addr[ADDR_WIDTH+1:2];
                    mis_d  = misaligned;
                    if (!misaligned && i_wr && (i_size == 2'b10)) begin
                        we_d    = 1'b1;
                        wdata_d = i_wdata;
                    end
                end
            end
            LD_DATA: begin
                valid_d = 1'b1;
                rdata_d = ld_ext;
            end
            RMW_MERGE: begin
                we_d    = 1'b1;
                wdata_d = merged;
            end
            ST_WRITE: valid_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req;
    logic        i_wr;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [10:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_stall;
    logic        o_mem_we;
    logic [8:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:511];
    logic        poke_en;
    logic [8:0]  poke_addr;
    logic [31:0] poke_data;
    int          we_cnt = 0;
    int          valid_cnt = 0;
    logic [8:0]  last_we_addr;
    logic [31:0] last_we_data;
    logic [31:0] vlog [$];

    dmem_lsu #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_wr         (i_wr),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_stall      (o_stall),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous-read memory plus write/valid counters.
    always @(posedge i_clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (o_mem_we) begin
            mem[o_mem_addr] <= o_mem_wdata;
            we_cnt++;
            last_we_addr <= o_mem_addr;
            last_we_data <= o_mem_wdata;
        end
        if (o_valid) valid_cnt++;
        i_mem_rdata <= mem[o_mem_addr];
    end

    always @(negedge i_clk) begin
        if (o_valid) vlog.push_back(o_rdata);
    end

    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [10:0] addr, input logic [31:0] wdata);
        i_wr       = wr;
        i_size     = size;
        i_unsigned = uns;
        i_addr     = addr;
        i_wdata    = wdata;
        i_req      = 1'b1;
        @(negedge i_clk);
        i_req      = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!o_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_req = 1'b0; i_wr = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
        i_addr = '0; i_wdata = '0;
        poke_en = 1'b1; poke_addr = 9'd5; poke_data = 32'h8899AABB;
        @(negedge i_clk);
        poke_en = 1'b0;
        @(negedge i_clk);
        n_checks++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", o_mem_we); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b expected 0", o_misaligned); end
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", o_rdata); end
        n_checks++; if (o_mem_addr !== 9'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", o_mem_addr); end
        n_checks++; if (o_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", o_mem_wdata); end
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        i_rst_n = 1'b1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    endtask

    task automatic test_byte_load;
        int n;
        issue(1'b0, 2'b00, 1'b0, 11'h016, 32'h0);
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL ldb_stall: got %b expected 1", o_stall); end
        n_checks++; if (o_mem_addr !== 9'd5) begin n_fail++; $display("FAIL ldb_addr: got %h expected 5", o_mem_addr); end
        wait_valid(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL ldb_latency: got %0d expected 3", n); end
        n_checks++; if (o_rdata !== 32'hFFFFFF99) begin n_fail++; $display("FAIL ldb_signed: got %h expected FFFFFF99", o_rdata); end
        @(negedge i_clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ldb_pulse: got %b expected 0", o_valid); end
        issue(1'b0, 2'b00, 1'b1, 11'h016, 32'h0);
        wait_valid(n);
        n_checks++; if (o_rdata !== 32'h00000099) begin n_fail++; $display("FAIL ldb_unsigned: got %h expected 00000099", o_rdata); end
        issue(1'b0, 2'b01, 1'b0, 11'h014, 32'h0);
        wait_valid(n);
        n_checks++; if (o_rdata !== 32'hFFFFAABB) begin n_fail++; $display("FAIL ldh_signed: got %h expected FFFFAABB", o_rdata); end
        issue(1'b0, 2'b01, 1'b1, 11'h016, 32'h0);
        wait_valid(n);
        n_checks++; if (o_rdata !== 32'h00008899) begin n_fail++; $display("FAIL ldh_unsigned: got %h expected 00008899", o_rdata); end
        @(negedge i_clk);
    endtask

    task automatic test_half_store;
        int n;
        int we0;
        we0 = we_cnt;
        issue(1'b1, 2'b01, 1'b0, 11'h016, 32'hFFFF1234);
        wait_valid(n);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL sth_latency: got %0d expected 4", n); end
        n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL sth_we_count: got %0d expected 1", we_cnt - we0); end
        n_checks++; if (last_we_addr !== 9'd5) begin n_fail++; $display("FAIL sth_addr: got %h expected 5", last_we_addr); end
        n_checks++; if (last_we_data !== 32'h1234AABB) begin n_fail++; $display("FAIL sth_wdata: got %h expected 1234AABB", last_we_data); end
        n_checks++; if (o_rdata !== 32'h00008899) begin n_fail++; $display("FAIL sth_rdata_hold: got %h expected 00008899", o_rdata); end
        @(negedge i_clk);
        issue(1'b0, 2'b10, 1'b0, 11'h014, 32'h0);
        wait_valid(n);
        n_checks++; if (o_rdata !== 32'h1234AABB) begin n_fail++; $display("FAIL sth_readback: got %h expected 1234AABB", o_rdata); end
        @(negedge i_clk);
    endtask

    task automatic test_word_store_load;
        int n;
        int we0;
        we0 = we_cnt;
        issue(1'b1, 2'b10, 1'b0, 11'h020, 32'hDEADBEEF);
        wait_valid(n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL stw_latency: got %0d expected 2", n); end
        n_checks++; if (we_cnt - we0 !== 1) begin n_fail++; $display("FAIL stw_we_count: got %0d expected 1", we_cnt - we0); end
        n_checks++; if (last_we_addr !== 9'd8) begin n_fail++; $display("FAIL stw_addr: got %h expected 8", last_we_addr); end
        n_checks++; if (last_we_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stw_wdata: got %h expected DEADBEEF", last_we_data); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stw_ready_in_valid: got %b expected 1", o_ready); end
        issue(1'b0, 2'b10, 1'b0, 11'h020, 32'h0);
        wait_valid(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL ldw_latency: got %0d expected 3", n); end
        n_checks++; if (o_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_readback: got %h expected DEADBEEF", o_rdata); end
        @(negedge i_clk);
    endtask

    task automatic test_misaligned;
        int we0;
        int v0;
        we0 = we_cnt;
        v0  = valid_cnt;
        issue(1'b0, 2'b10, 1'b0, 11'h015, 32'h0);
        n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_word: got %b expected 1", o_misaligned); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mis_word_ready: got %b expected 1", o_ready); end
        @(negedge i_clk);
        n_checks++; if (o_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b expected 0", o_misaligned); end
        issue(1'b1, 2'b01, 1'b0, 11'h017, 32'h00000077);
        n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_half: got %b expected 1", o_misaligned); end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL mis_half_ready: got %b expected 1", o_ready); end
        issue(1'b0, 2'b11, 1'b0, 11'h014, 32'h0);
        n_checks++; if (o_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_size11: got %b expected 1", o_misaligned); end
        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL mis_no_we: got %0d expected 0", we_cnt - we0); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL mis_no_valid: got %0d expected 0", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_rmw;
        int n;
        int we0;
        int v0;
        we0 = we_cnt;
        v0  = valid_cnt;
        issue(1'b1, 2'b00, 1'b0, 11'h014, 32'h00000055);
        @(negedge i_clk);
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_busy: got %b expected 1", o_stall); end
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: got %b expected 0", o_stall); end
        n_checks++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_async_we: got %b expected 0", o_mem_we); end
        @(negedge i_clk);
        n_checks++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_held_we: got %b expected 0", o_mem_we); end
        i_rst_n = 1'b1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", o_ready); end
        @(negedge i_clk);
        n_checks++; if (mem[5] !== 32'h1234AABB) begin n_fail++; $display("FAIL rst_word_kept: got %h expected 1234AABB", mem[5]); end
        n_checks++; if (we_cnt - we0 !== 0) begin n_fail++; $display("FAIL rst_no_we: got %0d expected 0", we_cnt - we0); end
        n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d expected 0", valid_cnt - v0); end
        issue(1'b0, 2'b10, 1'b0, 11'h014, 32'h0);
        wait_valid(n);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rst_first_load_latency: got %0d expected 3", n); end
        n_checks++; if (o_rdata !== 32'h1234AABB) begin n_fail++; $display("FAIL rst_first_load: got %h expected 1234AABB", o_rdata); end
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back;
        logic        wr_t   [3];
        logic [1:0]  size_t [3];
        logic [10:0] addr_t [3];
        logic [31:0] data_t [3];
        int acc [3];
        int cyc;
        int n;
        int stall_bad;
        wr_t[0] = 1'b0; size_t[0] = 2'b10; addr_t[0] = 11'h014; data_t[0] = 32'h0;
        wr_t[1] = 1'b1; size_t[1] = 2'b00; addr_t[1] = 11'h020; data_t[1] = 32'h123456A5;
        wr_t[2] = 1'b0; size_t[2] = 2'b10; addr_t[2] = 11'h020; data_t[2] = 32'h0;
        vlog.delete();
        cyc = 0;
        stall_bad = 0;
        i_unsigned = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_wr = wr_t[k]; i_size = size_t[k]; i_addr = addr_t[k]; i_wdata = data_t[k];
            i_req = 1'b1;
            n = 0;
            while (!o_ready && n < 20) begin
                if (o_stall !== 1'b1) stall_bad++;
                @(negedge i_clk);
                cyc++;
                n++;
            end
            acc[k] = cyc;
            @(negedge i_clk);
            cyc++;
        end
        i_req = 1'b0;
        n = 0;
        while (vlog.size() < 3 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        n_checks++; if (acc[1] - acc[0] !== 3) begin n_fail++; $display("FAIL b2b_gap_load: got %0d expected 3", acc[1] - acc[0]); end
        n_checks++; if (acc[2] - acc[1] !== 4) begin n_fail++; $display("FAIL b2b_gap_rmw: got %0d expected 4", acc[2] - acc[1]); end
        n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL b2b_stall: got %0d bad cycles expected 0", stall_bad); end
        n_checks++; if (vlog.size() !== 3) begin n_fail++; $display("FAIL b2b_completions: got %0d expected 3", vlog.size()); end
        if (vlog.size() == 3) begin
            n_checks++; if (vlog[0] !== 32'h1234AABB) begin n_fail++; $display("FAIL b2b_load0: got %h expected 1234AABB", vlog[0]); end
            n_checks++; if (vlog[1] !== 32'h1234AABB) begin n_fail++; $display("FAIL b2b_store_hold: got %h expected 1234AABB", vlog[1]); end
            n_checks++; if (vlog[2] !== 32'hDEADBEA5) begin n_fail++; $display("FAIL b2b_load2: got %h expected DEADBEA5", vlog[2]); end
        end
        n_checks++; if (mem[8] !== 32'hDEADBEA5) begin n_fail++; $display("FAIL b2b_mem8: got %h expected DEADBEA5", mem[8]); end
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_store();
        test_word_store_load();
        test_misaligned();
        test_reset_mid_rmw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 9, as the word-address width of the data memory.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, as the memory word width; only 32 is supported.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed as follows.
- i_clk  in  1  clock; all state is rising-edge.
- i_rst_n  in  1  asynchronous reset, active low.
REQ-004 The pipeline-side ports SHALL be as follows.
- i_req  in  1  request valid.
- i_wr  in  1  1=store, 0=load.
- i_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- i_unsigned  in  1  zero-extend loads when 1.
- i_addr  in  ADDR_WIDTH+2  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  request accepted when i_req and o_ready are both high at a rising edge.
- o_valid  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load result.
- o_misaligned  out  1  one-cycle error pulse.
- o_stall  out  1  pipeline hold.
REQ-005 The memory-side ports SHALL be as follows.
- o_mem_we  out  1  write enable.
- o_mem_addr  out  ADDR_WIDTH  word address.
- o_mem_wdata  out  32  write word.
- i_mem_rdata  in  32  read word, valid one clock after o_mem_addr.

Function
REQ-006 o_mem_we, o_mem_addr, o_mem_wdata, o_rdata, o_valid and o_misaligned SHALL be registered outputs.
REQ-007 FSM states SHALL be IDLE, LD_WAIT, LD_DATA, RMW_WAIT, RMW_MERGE and ST_WRITE.
REQ-008 o_ready SHALL equal (state==IDLE); o_stall SHALL equal (state!=IDLE).
REQ-009 On acceptance, o_mem_addr SHALL load i_addr[ADDR_WIDTH+1:2], and size, lane (i_addr[1:0]), unsigned flag and wdata SHALL be latched.
REQ-010 Misalignment SHALL be defined as: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- On an accepted misaligned request: o_misaligned=1 for exactly the next cycle.
- State SHALL remain IDLE.
- There SHALL be no o_mem_we and no o_valid.
REQ-011 The load path SHALL be IDLE -> LD_WAIT -> LD_DATA -> IDLE.
- On the LD_DATA exit edge, o_rdata SHALL register the extracted value and o_valid SHALL be 1 for one cycle.
- Latency SHALL be acceptance edge + 3 edges.
REQ-012 Load extraction SHALL be little-endian.
- byte = rdata[8*lane+7:8*lane].
- half = rdata[16*lane[1]+15:16*lane[1]].
- Byte and half results SHALL be sign-extended unless i_unsigned=1; word loads SHALL pass through.
REQ-013 A word store SHALL run IDLE -> ST_WRITE, with the acceptance edge setting o_mem_we=1 and o_mem_wdata=i_wdata.
REQ-014 Leaving ST_WRITE SHALL clear o_mem_we and pulse o_valid, so o_mem_we is high for exactly one cycle per store.
REQ-015 A byte or half store SHALL perform read-modify-write: IDLE -> RMW_WAIT -> RMW_MERGE -> ST_WRITE -> IDLE.
REQ-016 In RMW_MERGE, the merged word (i_mem_rdata with the addressed lane(s) replaced by i_wdata[7:0] or [15:0]) SHALL be registered into o_mem_wdata with o_mem_we=1.
REQ-017 o_mem_addr SHALL be held constant from acceptance until return to IDLE.
REQ-018 A new request SHALL be acceptable in the same cycle o_valid or o_misaligned is high.
REQ-019 o_rdata SHALL hold its last load value until the next load completes; stores SHALL not modify it.
REQ-020 i_req seen while not in IDLE SHALL be ignored.

Reset
REQ-021 Assertion of i_rst_n=0 SHALL immediately (asynchronously) force state=IDLE and all outputs to 0, including o_mem_we.
REQ-022 A reset in any state, including RMW_MERGE or ST_WRITE, SHALL cause no further memory write, and the in-flight request SHALL be discarded without o_valid.
REQ-023 After deassertion, o_ready SHALL be 1 and the first request SHALL be accepted on the first rising edge with i_req=1.

Verification
REQ-024 Byte load: memory word 5 = 0x8899AABB, load byte addr 0x016 signed -> o_valid 3 edges after accept, o_rdata=0xFFFFFF99; repeated with i_unsigned=1 -> 0x00000099.
REQ-025 Half store: 0x1234 to 0x016 -> o_mem_we exactly one cycle, o_mem_addr=5, o_mem_wdata=0x1234AABB, o_valid 4 edges after accept; subsequent word load of 0x014 returns 0x1234AABB.
REQ-026 Word store then load: 0xDEADBEEF to 0x020 -> o_mem_we one cycle with addr 8; a load issued in the o_valid cycle returns 0xDEADBEEF.
REQ-027 Misaligned word load at 0x015, and half store at 0x017 -> o_misaligned single pulse, o_mem_we never high, o_valid never high, o_ready stays 1.
REQ-028 Reset mid-RMW: byte store issued, i_rst_n=0 while in RMW_MERGE -> o_mem_we 0 immediately, word unchanged, o_valid 0, o_ready=1 after release.
REQ-029 Back-to-back: load, store and load requests held on i_req -> each accepted only in IDLE, o_stall high between, completions in order.
